// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the single-cycle core_alu: instruction FIFO, operand read/forwarding,
// write-back formatting and branch redirect with wrong-path squash.
module alu_issue_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_insn,
  input  logic [63:0] in_pc,
  input  logic        halt,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [63:0] rf_rs1_data,
  input  logic [63:0] rf_rs2_data,
  output logic [31:0] alu_insn,
  output logic [63:0] alu_pc,
  output logic [63:0] alu_src1,
  output logic [63:0] alu_src2,
  input  logic        alu_dest_enable,
  input  logic        alu_dest_long,
  input  logic [63:0] alu_dest,
  input  logic        alu_br_en,
  input  logic [63:0] alu_br_target,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy,
  output logic [31:0] retired_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [6:0] {
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } ctrl_op_e;

  logic [31:0] insn_mem [DEPTH];
  logic [63:0] pc_mem   [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, issue;
  logic [31:0] head_insn;
  logic [63:0] head_pc;

  logic        inflight_v;
  logic [4:0]  inflight_rd;
  logic [6:0]  inflight_op;
  logic        fwd1, fwd2, ctrl_op;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_insn = insn_mem[rd_ptr[AW-1:0]];
  assign head_pc   = pc_mem[rd_ptr[AW-1:0]];

  assign in_ready = !full && !redirect_valid;
  assign push     = in_valid && in_ready;
  assign issue    = !empty && !halt && !redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      insn_mem <= '{default: '0};
      pc_mem   <= '{default: '0};
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        insn_mem[wr_ptr[AW-1:0]] <= in_insn;
        pc_mem[wr_ptr[AW-1:0]]   <= in_pc;
        wr_ptr                   <= wr_ptr + PTR_ONE;
      end
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_v    <= 1'b0;
      inflight_rd   <= '0;
      inflight_op   <= '0;
      retired_count <= '0;
    end else begin
      inflight_v <= issue;
      if (issue) begin
        inflight_rd <= head_insn[11:7];
        inflight_op <= head_insn[6:0];
      end
      if (inflight_v) retired_count <= retired_count + 32'd1;
    end
  end

  assign rf_rs1_addr = head_insn[19:15];
  assign rf_rs2_addr = head_insn[24:20];

  always_comb begin
    alu_insn = '0;
    alu_pc   = '0;
    if (issue) begin
      alu_insn = head_insn;
      alu_pc   = head_pc;
    end
  end

  assign wb_valid = inflight_v && alu_dest_enable && (inflight_rd != 5'd0);
  assign wb_rd    = inflight_rd;
  assign wb_data  = alu_dest_long ? alu_dest : {{32{alu_dest[31]}}, alu_dest[31:0]};

  // Forward the result being written this cycle, since the register file updates only at the edge.
  assign fwd1     = wb_valid && (wb_rd == rf_rs1_addr) && (rf_rs1_addr != 5'd0);
  assign fwd2     = wb_valid && (wb_rd == rf_rs2_addr) && (rf_rs2_addr != 5'd0);
  assign alu_src1 = fwd1 ? wb_data : rf_rs1_data;
  assign alu_src2 = fwd2 ? wb_data : rf_rs2_data;

  assign ctrl_op = (inflight_op == OP_JAL) || (inflight_op == OP_JALR) || (inflight_op == OP_BRANCH);
  assign redirect_valid = inflight_v && alu_br_en && ctrl_op;
  assign redirect_pc    = alu_br_target;

  assign busy = !empty || inflight_v;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: stand-in core_alu and register file, expected write-backs and
// redirects derived from in-order program semantics, directed cases plus a random phase.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [63:0] in_pc;
  logic        halt;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [63:0] rf_rs1_data, rf_rs2_data;
  logic [31:0] alu_insn;
  logic [63:0] alu_pc, alu_src1, alu_src2;
  logic        alu_dest_enable, alu_dest_long, alu_br_en;
  logic [63:0] alu_dest, alu_br_target;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        busy;
  logic [31:0] retired_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_retired = 0;
  logic [68:0] exp_wb [$];
  logic [63:0] exp_redir [$];
  logic [63:0] rf [32];
  logic [63:0] ref_regs [32];

  alu_issue_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .halt(halt),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .alu_insn(alu_insn), .alu_pc(alu_pc), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_dest_enable(alu_dest_enable), .alu_dest_long(alu_dest_long), .alu_dest(alu_dest),
    .alu_br_en(alu_br_en), .alu_br_target(alu_br_target),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, written at the edge.
  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];
  always @(posedge clk)
    if (!reset && wb_valid && wb_rd != 5'd0) rf[wb_rd] <= wb_data;

  // Minimal registered core_alu: ADDI, ADD, ADDIW, AUIPC, BEQ, JAL.
  logic [63:0] imm_i, imm_u, imm_b, imm_j, sum_i;
  assign imm_i = {{52{alu_insn[31]}}, alu_insn[31:20]};
  assign imm_u = {{32{alu_insn[31]}}, alu_insn[31:12], 12'h0};
  assign imm_b = {{52{alu_insn[31]}}, alu_insn[7], alu_insn[30:25], alu_insn[11:8], 1'b0};
  assign imm_j = {{44{alu_insn[31]}}, alu_insn[19:12], alu_insn[20], alu_insn[30:21], 1'b0};
  assign sum_i = alu_src1 + imm_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_dest_enable <= 1'b0; alu_dest_long <= 1'b0; alu_dest <= '0;
      alu_br_en <= 1'b0; alu_br_target <= '0;
    end else begin
      alu_dest_enable <= 1'b0; alu_dest_long <= 1'b1; alu_dest <= '0;
      alu_br_en <= 1'b0; alu_br_target <= '0;
      case (alu_insn[6:0])
        7'h13: begin alu_dest_enable <= 1'b1; alu_dest <= sum_i; end
        7'h33: begin alu_dest_enable <= 1'b1; alu_dest <= alu_src1 + alu_src2; end
        7'h1B: begin
          // Upper half deliberately junk: the DUT must sign-extend bit 31.
          alu_dest_enable <= 1'b1; alu_dest_long <= 1'b0;
          alu_dest <= {32'hDEADBEEF, sum_i[31:0]};
        end
        7'h17: begin
          alu_dest_enable <= 1'b1; alu_dest <= alu_pc + imm_u;
          alu_br_en <= 1'b1; alu_br_target <= alu_pc + imm_u;
        end
        7'h63: begin alu_br_en <= (alu_src1 == alu_src2); alu_br_target <= alu_pc + imm_b; end
        7'h6F: begin
          alu_dest_enable <= 1'b1; alu_dest <= alu_pc + 64'd4;
          alu_br_en <= 1'b1; alu_br_target <= alu_pc + imm_j;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_addiw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0011011};
  endfunction
  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write-back and redirect must match the next expected one, in order.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        vectors++;
        assert (exp_wb.size() != 0) else begin
          miscompares++;
          $error("FAIL wb_unexpected observed rd=%0d data=%h expected none", wb_rd, wb_data);
        end
        if (exp_wb.size() != 0) check("wb_rd_data", {wb_rd, wb_data}, exp_wb.pop_front());
      end
      if (redirect_valid) begin
        vectors++;
        assert (exp_redir.size() != 0) else begin
          miscompares++;
          $error("FAIL redirect_unexpected observed pc=%h expected none", redirect_pc);
        end
        if (exp_redir.size() != 0) check("redirect_pc", redirect_pc, exp_redir.pop_front());
        check("in_ready_during_redirect", in_ready, 0);
      end
    end
  end

  task automatic push(input logic [31:0] i, input logic [63:0] p);
    int unsigned n = 0;
    in_valid = 1'b1; in_insn = i; in_pc = p;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("push_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b0 && exp_wb.size() == 0 && exp_redir.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pending"}, 64'(exp_wb.size() + exp_redir.size()), 0);
    check({tag, "_retired"}, retired_count, exp_retired);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wb"}, {wb_valid, wb_rd, wb_data}, 0);
    check({tag, "_redirect"}, {redirect_valid, redirect_pc}, 0);
    check({tag, "_alu_insn_pc"}, {alu_insn, alu_pc[31:0]} | alu_pc, 0);
    check({tag, "_alu_src"}, alu_src1 | alu_src2, 0);
    check({tag, "_rf_addr"}, {rf_rs1_addr, rf_rs2_addr}, 0);
    check({tag, "_retired"}, retired_count, 0);
  endtask

  initial begin
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [63:0] res, sum;
    logic [31:0] ins;
    int unsigned op;

    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b1; in_valid = 1'b0; in_insn = '0; in_pc = '0; halt = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    // ADDI x1,x0,5 then ADD x2,x1,x1 back to back: second needs the forwarded x1.
    exp_wb.push_back({5'd1, 64'd5});
    exp_wb.push_back({5'd2, 64'd10});
    exp_retired += 2;
    push(32'h00500093, 64'h0);
    push(32'h00108133, 64'h4);
    wait_idle("t1");

    // ADDIW overflow sign-extends.
    rf[1] = 64'h7FFFFFFF;
    exp_wb.push_back({5'd3, 64'hFFFFFFFF80000000});
    exp_retired += 1;
    push(32'h0010819B, 64'h10);
    wait_idle("t2");

    // Taken BEQ squashes the two queued ADDIs.
    halt = 1'b1;
    push(32'h00000463, 64'h100);
    push(enc_addi(5'd6, 5'd0, 12'd1), 64'h104);
    push(enc_addi(5'd7, 5'd0, 12'd2), 64'h108);
    exp_redir.push_back(64'h108);
    exp_retired += 1;
    halt = 1'b0;
    wait_idle("t3");

    // AUIPC: its branch flag must not redirect.
    exp_wb.push_back({5'd5, 64'h1200});
    exp_retired += 1;
    push(32'h00001297, 64'h200);
    wait_idle("t4");

    // JAL writes PC+4 and redirects.
    exp_wb.push_back({5'd1, 64'h304});
    exp_redir.push_back(64'h310);
    exp_retired += 1;
    push(32'h010000EF, 64'h300);
    wait_idle("jal");

    // Halt fills the FIFO, release drains one per cycle.
    halt = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp_wb.push_back({5'(k), 64'(k)});
      push(enc_addi(5'(k), 5'd0, 12'(k)), 64'h400 + 64'(4 * k));
    end
    check("t5_full_in_ready", in_ready, 0);
    exp_retired += 4;
    halt = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("t5_wb_consecutive", wb_valid, 1);
      @(negedge clk);
    end
    wait_idle("t5");

    // Write to x0: no write-back, still retires.
    exp_retired += 1;
    push(32'h00700013, 64'h500);
    wait_idle("t6");

    // Random ADDI/ADD/ADDIW program against in-order architectural model.
    for (int i = 0; i < 32; i++) ref_regs[i] = rf[i];
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 2);
      rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      imm = 12'($urandom);
      sum = ref_regs[rs1] + {{52{imm[11]}}, imm};
      case (op)
        0: begin ins = enc_addi(rd, rs1, imm); res = sum; end
        1: begin ins = enc_add(rd, rs1, rs2); res = ref_regs[rs1] + ref_regs[rs2]; end
        default: begin ins = enc_addiw(rd, rs1, imm); res = {{32{sum[31]}}, sum[31:0]}; end
      endcase
      if (rd != 5'd0) begin
        exp_wb.push_back({rd, res});
        ref_regs[rd] = res;
      end
      exp_retired += 1;
      halt = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      halt = 1'b0;
      push(ins, 64'h1000 + 64'(4 * k));
    end
    wait_idle("rand");

    // Reset in the middle of a drain.
    halt = 1'b1;
    exp_wb.push_back({5'd4, 64'd9});
    push(enc_addi(5'd4, 5'd0, 12'd9), 64'h600);
    push(enc_addi(5'd5, 5'd0, 12'd8), 64'h604);
    push(enc_addi(5'd6, 5'd0, 12'd7), 64'h608);
    halt = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    exp_wb.delete();
    exp_retired = 0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
